spi_cmd_ctrl: RTL and testbench
===============================

// Module: spi_cmd_ctrl
// PURPOSE
//  Command sequencer behind spi_slave.
//  - Takes each completed SPI word and decodes it as opcode/address/data.
//  - Writes a shadow register bank.
//  - Commits shadow to active registers, either immediately or on the next
//    frame boundary, so output generators never see a half-updated config.
//  - Sits in the clk domain between spi_slave and the pulse/LED generators.
// PARAMETERS
//  WIDTH   24  SPI word width; must match spi_slave width
//  DW      16  register data width; field spi_word[DW-1:0]
//  AW      4   address field width; field spi_word[DW+AW-1:DW]
//  NREGS   16  implemented registers, 1..2**AW
//  OPW     4   opcode width; field spi_word[WIDTH-1:WIDTH-OPW]; WIDTH==OPW+AW+DW
// PORTS
//  clk             in   1         system clock
//  reset_n         in   1         asynchronous reset, active-low
//  spi_word        in   WIDTH     spi_slave shiftreg; stable while spi_data_ready high
//  spi_data_ready  in   1         spi_slave data_ready (synchronised level, high until nCS rises)
//  frame_sync      in   1         1-cycle frame boundary strobe
//  active_regs     out  NREGS*DW  committed registers, reg i at [i*DW +: DW]
//  commit_pulse    out  1         1-cycle strobe, cycle after active_regs updates
//  commit_pending  out  1         COMMIT_SYNC armed, waiting for frame_sync
//  cmd_count       out  16        accepted (legal) commands, wraps 0xFFFF->0
//  err_count       out  8         rejected commands, saturates at 0xFF
// BEHAVIOUR
//  Reset (reset_n low, any time, async):
//  - shadow, active_regs, commit_pulse, commit_pending, cmd_count, err_count all <= 0.
//  - Edge-detect flop <= 0; command slot <= invalid.
//  - Any in-flight word is dropped.
//  Capture:
//  - Register spi_data_ready as dr_q.
//  - Rising edge is (spi_data_ready & ~dr_q); on it, latch spi_word into cmd_q and set cmd_v.
//  - A level held high (long nCS) yields exactly one command.
//  - Upstream keeps nCS low >=4 clk after the last SCK edge (word clears on nCS).
//  Execute:
//  - The edge after capture decodes cmd_q and clears cmd_v.
//  - Latency: edge detected at edge k -> shadow/active effect visible after edge k+1.
//  Opcodes (shared package):
//  - 0x0 NOP: count only.
//  - 0x1 WRITE: shadow[addr] <= data.
//  - 0x2 COMMIT_NOW: active <= shadow; clears commit_pending.
//  - 0x3 COMMIT_SYNC: set commit_pending; re-arming while already pending is a no-op.
//  - 0x4 REVERT: shadow <= active.
//  - 0x5 CANCEL: clear commit_pending.
//  - Other opcodes: illegal.
//  Counters:
//  - Illegal opcode, or WRITE with addr >= NREGS: no state change, err_count +1 (saturating).
//  - Every legal command: cmd_count +1.
//  Sync commit:
//  - frame_sync while commit_pending: active <= shadow, commit_pending <= 0.
//  - frame_sync while not pending: ignored.
//  commit_pulse:
//  - High for exactly 1 cycle after any active update (NOW or SYNC).
//  - Two commits on consecutive cycles give two pulses.
//  Simultaneous events, same edge:
//  - frame_sync + executing WRITE: active takes the old shadow; the write lands in shadow only.
//  - frame_sync + executing COMMIT_SYNC (not yet pending): arm only; commit on the next frame_sync.
//  - frame_sync + COMMIT_NOW: one copy, one commit_pulse.
//  - frame_sync + CANCEL while pending: frame_sync wins (commit), pending cleared.
//  - New rising edge while executing: capture proceeds in parallel (1 slot suffices; words are >=WIDTH SCKs apart).
// STRUCTURE
//  Package spi_cmd_pkg:
//  - opcode enum cmd_op_e.
//  - Field position localparams (OP_LSB, ADDR_LSB).
//  - Struct spi_cmd_t {op, addr, data}.
//  Sub-module spi_shadow_bank (NREGS, DW):
//  - Shadow + active arrays; write port, commit, revert.
//  - Commit/revert take the pre-write shadow on coincident edges.
//  Top: edge detect, command slot, decode/pending FSM (IDLE/PENDING), counters.
// TESTING
//  - Reset, then WRITE 0x1_3_BEEF -> shadow[3]=0xBEEF, active_regs[3]=0, cmd_count=1.
//  - WRITE reg2=0x1234 then COMMIT_NOW (0x200000) -> active[2]=0x1234 after edge k+1; commit_pulse 1 cycle.
//  - COMMIT_SYNC, hold data_ready high 50 cycles -> one command; pending=1 until frame_sync; commit then pending=0.
//  - Opcode 0xF and WRITE addr 0xF (NREGS=8) -> err_count=2, regs unchanged; 300 bad cmds -> err_count=0xFF.
//  - frame_sync same edge as WRITE reg0=0xAAAA while pending -> active[0]=old shadow; shadow[0]=0xAAAA.
//  - reset_n low mid-command (between capture and execute) -> all outputs 0; no write after release.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command sequencer: opcodes, default field
// positions and the decoded command layout.
package spi_cmd_pkg;

    localparam int WIDTH_DEF = 24;
    localparam int DW_DEF    = 16;
    localparam int AW_DEF    = 4;
    localparam int OPW_DEF   = 4;

    localparam int ADDR_LSB  = DW_DEF;
    localparam int OP_LSB    = DW_DEF + AW_DEF;

    typedef enum logic [OPW_DEF-1:0] {
        OP_NOP         = 4'h0,
        OP_WRITE       = 4'h1,
        OP_COMMIT_NOW  = 4'h2,
        OP_COMMIT_SYNC = 4'h3,
        OP_REVERT      = 4'h4,
        OP_CANCEL      = 4'h5
    } cmd_op_e;

    typedef struct packed {
        cmd_op_e            op;
        logic [AW_DEF-1:0]  addr;
        logic [DW_DEF-1:0]  data;
    } spi_cmd_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } pend_state_e;

endpackage

// File: rtl/spi_shadow_bank.sv
// Shadow/active register pair per address. Commit and revert always read the
// register values from before this edge, so coincident write+commit is clean.
module spi_shadow_bank #(
    parameter int NREGS = 16,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  commit,
    input  logic                  revert,
    output logic [NREGS*DW-1:0]   active_flat
);

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [DW-1:0] shadow_q, shadow_d;
            logic [DW-1:0] active_q, active_d;

            always_comb begin
                shadow_d = shadow_q;
                if (revert) begin
                    shadow_d = active_q;
                end
                if (wr_en && (wr_addr == AW'(gi))) begin
                    shadow_d = wr_data;
                end
                active_d = commit ? shadow_q : active_q;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    shadow_q <= '0;
                    active_q <= '0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                end
            end

            assign active_flat[gi*DW +: DW] = active_q;
        end
    endgenerate

endmodule

// File: rtl/spi_cmd_ctrl.sv
// Command sequencer behind spi_slave: captures each SPI word once, decodes it
// and drives the shadow bank, the sync-commit FSM and the command counters.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DW    = 16,
    parameter int AW    = 4,
    parameter int NREGS = 16,
    parameter int OPW   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      spi_word,
    input  logic                  spi_data_ready,
    input  logic                  frame_sync,
    output logic [NREGS*DW-1:0]   active_regs,
    output logic                  commit_pulse,
    output logic                  commit_pending,
    output logic [15:0]           cmd_count,
    output logic [7:0]            err_count
);

    localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

    logic              dr_q, dr_d;
    logic [WIDTH-1:0]  cmd_q, cmd_d;
    logic              cmd_v_q, cmd_v_d;
    pend_state_e       state_q, state_d;
    logic              commit_pulse_q, commit_pulse_d;
    logic [15:0]       cmd_count_q, cmd_count_d;
    logic [7:0]        err_count_q, err_count_d;

    logic [OPW-1:0]    op;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     data;
    logic              rise, exec;
    logic              is_write, is_now, is_sync, is_revert, is_cancel;
    logic              legal, sync_commit, do_commit, wr_en;

    assign op   = cmd_q[WIDTH-1 -: OPW];
    assign addr = cmd_q[DW +: AW];
    assign data = cmd_q[DW-1:0];
    assign rise = spi_data_ready & ~dr_q;
    assign exec = cmd_v_q;

    // A new edge may arrive on the same edge the previous command executes.
    always_comb begin
        dr_d    = spi_data_ready;
        cmd_d   = cmd_q;
        cmd_v_d = 1'b0;
        if (rise) begin
            cmd_d   = spi_word;
            cmd_v_d = 1'b1;
        end
    end

    always_comb begin
        is_write  = exec && (op == OPW'(OP_WRITE));
        is_now    = exec && (op == OPW'(OP_COMMIT_NOW));
        is_sync   = exec && (op == OPW'(OP_COMMIT_SYNC));
        is_revert = exec && (op == OPW'(OP_REVERT));
        is_cancel = exec && (op == OPW'(OP_CANCEL));
        legal     = (op <= OPW'(OP_CANCEL)) &&
                    !((op == OPW'(OP_WRITE)) && ({1'b0, addr} >= NREGS_L));
    end

    // Pending FSM: a frame_sync while pending wins over any coincident command.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_PENDING) && frame_sync) begin
            state_d = ST_IDLE;
        end else if (legal && (is_now || is_cancel)) begin
            state_d = ST_IDLE;
        end else if (legal && is_sync) begin
            state_d = ST_PENDING;
        end
    end

    always_comb begin
        sync_commit    = (state_q == ST_PENDING) && frame_sync;
        do_commit      = sync_commit || is_now;
        wr_en          = is_write && legal;
        commit_pulse_d = do_commit;
    end

    always_comb begin
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;
        if (exec) begin
            if (legal) begin
                cmd_count_d = cmd_count_q + 16'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dr_q           <= 1'b0;
            cmd_q          <= '0;
            cmd_v_q        <= 1'b0;
            state_q        <= ST_IDLE;
            commit_pulse_q <= 1'b0;
            cmd_count_q    <= '0;
            err_count_q    <= '0;
        end else begin
            dr_q           <= dr_d;
            cmd_q          <= cmd_d;
            cmd_v_q        <= cmd_v_d;
            state_q        <= state_d;
            commit_pulse_q <= commit_pulse_d;
            cmd_count_q    <= cmd_count_d;
            err_count_q    <= err_count_d;
        end
    end

    spi_shadow_bank #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_addr     (addr),
        .wr_data     (data),
        .commit      (do_commit),
        .revert      (is_revert),
        .active_flat (active_regs)
    );

    assign commit_pulse   = commit_pulse_q;
    assign commit_pending = (state_q == ST_PENDING);
    assign cmd_count      = cmd_count_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomised bench for spi_cmd_ctrl (NREGS=8): array-based reference model,
// commit snapshots scoreboarded against each commit_pulse.
module tb_spi_cmd_ctrl;
    import spi_cmd_pkg::*;

    localparam int NREGS = 8;
    localparam int DW    = 16;
    localparam int FW    = NREGS * DW;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [23:0]     spi_word = '0;
    logic            spi_data_ready = 1'b0;
    logic            frame_sync = 1'b0;
    logic [FW-1:0]   active_regs;
    logic            commit_pulse;
    logic            commit_pending;
    logic [15:0]     cmd_count;
    logic [7:0]      err_count;

    spi_cmd_ctrl #(
        .WIDTH (24),
        .DW    (DW),
        .AW    (4),
        .NREGS (NREGS),
        .OPW   (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi_word       (spi_word),
        .spi_data_ready (spi_data_ready),
        .frame_sync     (frame_sync),
        .active_regs    (active_regs),
        .commit_pulse   (commit_pulse),
        .commit_pending (commit_pending),
        .cmd_count      (cmd_count),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    logic [15:0]    m_sh [NREGS];
    logic [15:0]    m_act[NREGS];
    bit             m_pend;
    int             m_cmd;
    int             m_err;
    logic [FW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;

    function automatic logic [FW-1:0] pack_act();
        logic [FW-1:0] r;
        for (int i = 0; i < NREGS; i++) r[i*DW +: DW] = m_act[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
        end
        m_pend = 0;
        m_cmd  = 0;
        m_err  = 0;
        exp_q.delete();
    endtask

    task automatic model_fsync();
        if (m_pend) begin
            m_act  = m_sh;
            m_pend = 0;
            exp_q.push_back(pack_act());
        end
    endtask

    task automatic model_exec(input logic [23:0] w, input bit fs);
        spi_cmd_t    c;
        logic [3:0]  opv;
        logic [15:0] old_sh [NREGS];
        logic [15:0] old_act[NREGS];
        bit          sync, commit, legal, new_pend;
        c        = spi_cmd_t'(w);
        opv      = c.op;
        old_sh   = m_sh;
        old_act  = m_act;
        sync     = fs && m_pend;
        commit   = sync;
        new_pend = m_pend;
        legal    = (opv <= 4'h5) && !((opv == 4'h1) && (c.addr >= 4'(NREGS)));
        if (!legal) begin
            if (m_err < 255) m_err++;
        end else begin
            m_cmd = (m_cmd + 1) % 65536;
            case (opv)
                4'h1: m_sh[int'(c.addr)] = c.data;
                4'h2: begin m_act = old_sh; commit = 1; new_pend = 0; end
                4'h3: new_pend = 1;
                4'h4: m_sh = old_act;
                4'h5: new_pend = 0;
                default: ;
            endcase
        end
        if (sync) begin
            m_act    = old_sh;
            new_pend = 0;
        end
        m_pend = new_pend;
        if (commit) exp_q.push_back(pack_act());
    endtask

    // fs_mode: 0 none, 1 frame_sync on the execute edge, 2 on the capture edge
    task automatic send(input logic [23:0] w, input int hold, input int fs_mode);
        @(posedge clk); #1;
        spi_word       = w;
        spi_data_ready = 1'b1;
        frame_sync     = (fs_mode == 2);
        @(posedge clk); #1;
        if (fs_mode == 2) model_fsync();
        frame_sync = (fs_mode == 1);
        check("active_before_exec", active_regs, pack_act());
        @(posedge clk); #1;
        frame_sync = 1'b0;
        model_exec(w, fs_mode == 1);
        check("active_after_exec", active_regs, pack_act());
        check("cmd_count", FW'(cmd_count), FW'(m_cmd));
        check("err_count", FW'(err_count), FW'(m_err));
        check("commit_pending", FW'(commit_pending), FW'(m_pend));
        repeat (hold) @(posedge clk);
        #1;
        check("cmd_count_held", FW'(cmd_count), FW'(m_cmd));
        spi_data_ready = 1'b0;
        spi_word       = 24'($urandom);
        repeat (2) @(posedge clk);
    endtask

    task automatic fsync();
        @(posedge clk); #1;
        frame_sync = 1'b1;
        @(posedge clk); #1;
        frame_sync = 1'b0;
        model_fsync();
        check("fsync_active", active_regs, pack_act());
        check("fsync_pending", FW'(commit_pending), FW'(m_pend));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, active_regs, '0);
        check({tag, "_pulse"}, FW'(commit_pulse), '0);
        check({tag, "_pending"}, FW'(commit_pending), '0);
        check({tag, "_cmd"}, FW'(cmd_count), '0);
        check({tag, "_err"}, FW'(err_count), '0);
    endtask

    // Scoreboard monitor: every commit_pulse consumes one expected snapshot.
    always @(negedge clk) begin
        logic [FW-1:0] e;
        if (reset_n && commit_pulse) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL commit_pulse_unexpected: got pulse expected none, active %h", active_regs);
            end else begin
                e = exp_q.pop_front();
                check("commit_snapshot", active_regs, e);
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [3:0]  addr;
        int          r;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        send(24'h13BEEF, 0, 0);
        send(24'h121234, 0, 0);
        send(24'h200000, 0, 0);
        send(24'h110055, 0, 0);
        send(24'h300000, 50, 0);
        repeat (5) @(posedge clk);
        fsync();
        fsync();
        send(24'hF00000, 0, 0);
        send(24'h1F0001, 0, 0);
        send(24'h300000, 0, 0);
        send(24'h10AAAA, 0, 1);
        send(24'h200000, 0, 0);
        send(24'h300000, 0, 1);
        fsync();
        send(24'h300000, 0, 0);
        send(24'h500000, 0, 1);
        send(24'h300000, 0, 0);
        send(24'h200000, 0, 2);
        send(24'h145678, 0, 0);
        send(24'h400000, 0, 0);
        send(24'h200000, 0, 0);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 11);
            op = (r <= 5) ? 4'(r) : ((r <= 9) ? 4'h1 : 4'(6 + (r % 2) * 9));
            addr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            send({op, addr, 16'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) fsync();
        end

        @(posedge clk); #1;
        spi_word       = 24'h111111;
        spi_data_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        spi_data_ready = 1'b0;
        model_reset();
        #1;
        check_all_zero("midcmd_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("after_release");
        send(24'h200000, 0, 0);

        for (int i = 0; i < 300; i++) begin
            send(24'hF00000, 0, 0);
        end
        check("err_saturated", FW'(err_count), FW'(8'hFF));

        repeat (4) @(posedge clk);
        #1;
        check("pulses_outstanding", FW'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
